// File: rtl/sin_bank.sv
// sin_bank: time-multiplexed bank of VOICES sine partials sharing one CORDIC.
// One summed mix sample per sample_req. Build option: SIN_BANK_SAT_EN.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   cfg_we          config write strobe
//   cfg_addr        voice index
//   cfg_sel         0 = phase increment, 1 = gain (cfg_data[GAIN_W-1:0])
//   cfg_data        config payload
//   sample_req      start a frame (ignored while busy)
//   sample_out      signed mix, held until the next frame completes
//   sample_valid    1-cycle pulse when sample_out updates
//   busy            frame in progress
//
// SIN_BANK_SAT_EN defined  : mix = acc saturated to +/-(2^(OUT_W-1)-1)
// SIN_BANK_SAT_EN undefined: mix = acc >>> log2(VOICES)
// ITER must not exceed 32 (arctan ROM depth).
`timescale 1ns/1ps
module sin_bank #(
  parameter int VOICES  = 8,
  parameter int PHASE_W = 32,
  parameter int OUT_W   = 16,
  parameter int GAIN_W  = 8,
  parameter int ITER    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_we,
  input  logic [$clog2(VOICES)-1:0] cfg_addr,
  input  logic                      cfg_sel,
  input  logic [PHASE_W-1:0]        cfg_data,
  input  logic                      sample_req,
  output logic [OUT_W-1:0]          sample_out,
  output logic                      sample_valid,
  output logic                      busy
);

  localparam int VW = $clog2(VOICES);
  localparam int AW = OUT_W + VW;
  localparam int G  = 4;
  localparam int XW = OUT_W + G + 2;
  localparam int ZW = 32;
  localparam int IW = $clog2(ITER + 1);
  localparam int PW = OUT_W + GAIN_W + 1;

  localparam logic [63:0] AMP = (64'd1 << (OUT_W - 1)) - 64'd1;
  // x0 = amplitude * K^-1 with G guard bits; 0x9B74EDA8 = K^-1 in Q0.32
  localparam logic [63:0] X0_64 =
    ((AMP << G) * 64'd2608131496 + (64'd1 << 31)) >> 32;
  localparam logic signed [XW-1:0]    X0     = XW'(X0_64);
  localparam logic signed [XW-1:0]    SMAX_X = XW'(AMP);
  localparam logic signed [OUT_W-1:0] SMAX_S = OUT_W'(AMP);
  localparam logic signed [AW-1:0]    SMAX_A = AW'(AMP);
  localparam logic signed [XW-1:0]    RND    = XW'(64'd1 << (G - 1));
  localparam logic [ZW-1:0]           HALF   = {1'b1, {(ZW-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ITER,
    S_ACCUM,
    S_DONE
  } state_t;

  // atan(2^-i) with one full turn = 2^32
  function automatic logic [ZW-1:0] atan_rom(input logic [4:0] i);
    unique case (i)
      5'd0:  atan_rom = 32'h20000000;
      5'd1:  atan_rom = 32'h12E4051E;
      5'd2:  atan_rom = 32'h09FB385B;
      5'd3:  atan_rom = 32'h051111D4;
      5'd4:  atan_rom = 32'h028B0D43;
      5'd5:  atan_rom = 32'h0145D7E1;
      5'd6:  atan_rom = 32'h00A2F61E;
      5'd7:  atan_rom = 32'h00517C55;
      5'd8:  atan_rom = 32'h0028BE53;
      5'd9:  atan_rom = 32'h00145F2F;
      5'd10: atan_rom = 32'h000A2F98;
      5'd11: atan_rom = 32'h000517CC;
      5'd12: atan_rom = 32'h00028BE6;
      5'd13: atan_rom = 32'h000145F3;
      5'd14: atan_rom = 32'h0000A2FA;
      5'd15: atan_rom = 32'h0000517D;
      5'd16: atan_rom = 32'h000028BE;
      5'd17: atan_rom = 32'h0000145F;
      5'd18: atan_rom = 32'h00000A30;
      5'd19: atan_rom = 32'h00000518;
      5'd20: atan_rom = 32'h0000028C;
      5'd21: atan_rom = 32'h00000146;
      5'd22: atan_rom = 32'h000000A3;
      5'd23: atan_rom = 32'h00000051;
      5'd24: atan_rom = 32'h00000029;
      5'd25: atan_rom = 32'h00000014;
      5'd26: atan_rom = 32'h0000000A;
      5'd27: atan_rom = 32'h00000005;
      5'd28: atan_rom = 32'h00000003;
      5'd29: atan_rom = 32'h00000001;
      5'd30: atan_rom = 32'h00000001;
      default: atan_rom = 32'h00000000;
    endcase
  endfunction

  state_t r_state;
  state_t w_next;

  logic [PHASE_W-1:0] r_phase [VOICES];
  logic [PHASE_W-1:0] r_inc   [VOICES];
  logic [GAIN_W-1:0]  r_gain  [VOICES];

  logic [VW-1:0]          r_voice;
  logic [IW-1:0]          r_it;
  logic signed [XW-1:0]   r_x;
  logic signed [XW-1:0]   r_y;
  logic signed [ZW-1:0]   r_z;
  logic [GAIN_W-1:0]      r_gcur;
  logic signed [AW-1:0]   r_acc;
  logic [OUT_W-1:0]       r_out;
  logic                   r_valid;
  logic                   r_busy;

  logic [PHASE_W-1:0]     w_p;
  logic [PHASE_W-1:0]     w_d;
  logic [ZW-1:0]          w_ang;
  logic                   w_mir;
  logic [ZW-1:0]          w_zf;
  logic [ZW-1:0]          w_atan;
  logic signed [XW-1:0]   w_xs;
  logic signed [XW-1:0]   w_ys;
  logic signed [XW-1:0]   w_yq;
  logic signed [OUT_W-1:0] w_s;
  logic signed [GAIN_W:0] w_g;
  logic signed [PW-1:0]   w_prod;
  logic signed [AW-1:0]   w_term;
  logic signed [OUT_W-1:0] w_mix;

  assign w_p = r_phase[r_voice];
  assign w_d = r_inc[r_voice];

  generate
    if (PHASE_W >= ZW) begin : g_ang_top
      assign w_ang = w_p[PHASE_W-1 -: ZW];
    end else begin : g_ang_pad
      assign w_ang = {w_p, {(ZW-PHASE_W){1'b0}}};
    end
  endgenerate

  // Quadrants 1 and 2 fold onto pi - theta; sine is unchanged
  assign w_mir = w_ang[ZW-1] ^ w_ang[ZW-2];
  assign w_zf  = w_mir ? (HALF - w_ang) : w_ang;

  assign w_atan = atan_rom(5'(r_it));
  assign w_xs   = r_x >>> r_it;
  assign w_ys   = r_y >>> r_it;

  assign w_yq = (r_y + RND) >>> G;

  always_comb begin
    w_s = OUT_W'(w_yq);
    if (w_yq > SMAX_X)
      w_s = SMAX_S;
    else if (w_yq < -SMAX_X)
      w_s = -SMAX_S;
  end

  assign w_g    = {1'b0, r_gcur};
  assign w_prod = PW'(w_s) * PW'(w_g);
  assign w_term = AW'(w_prod >>> GAIN_W);

`ifdef SIN_BANK_SAT_EN
  always_comb begin
    w_mix = OUT_W'(r_acc);
    if (r_acc > SMAX_A)
      w_mix = SMAX_S;
    else if (r_acc < -SMAX_A)
      w_mix = -SMAX_S;
  end
`else
  assign w_mix = OUT_W'(r_acc >>> VW);
`endif

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (sample_req) w_next = S_LOAD;
      S_LOAD:  w_next = S_ITER;
      S_ITER:  if (r_it == IW'(ITER - 1)) w_next = S_ACCUM;
      S_ACCUM: w_next = (r_voice == VW'(VOICES - 1)) ? S_DONE : S_LOAD;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < VOICES; v++) begin
        r_phase[v] <= '0;
        r_inc[v]   <= '0;
        r_gain[v]  <= '0;
      end
      r_voice <= '0;
      r_it    <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_gcur  <= '0;
      r_acc   <= '0;
      r_out   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (cfg_we) begin
        if (cfg_sel)
          r_gain[cfg_addr] <= cfg_data[GAIN_W-1:0];
        else
          r_inc[cfg_addr] <= cfg_data;
      end
      unique case (r_state)
        S_IDLE: begin
          if (sample_req) begin
            r_acc   <= '0;
            r_voice <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_LOAD: begin
          r_phase[r_voice] <= w_p + w_d;
          r_gcur <= r_gain[r_voice];
          r_it   <= '0;
          r_x    <= X0;
          r_y    <= '0;
          r_z    <= w_zf;
        end
        S_ITER: begin
          r_it <= r_it + IW'(1);
          if (r_z[ZW-1]) begin
            r_x <= r_x + w_ys;
            r_y <= r_y - w_xs;
            r_z <= r_z + w_atan;
          end else begin
            r_x <= r_x - w_ys;
            r_y <= r_y + w_xs;
            r_z <= r_z - w_atan;
          end
        end
        S_ACCUM: begin
          r_acc   <= r_acc + w_term;
          r_voice <= r_voice + VW'(1);
        end
        S_DONE: begin
          r_out   <= w_mix;
          r_valid <= 1'b1;
          r_busy  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign sample_out   = r_out;
  assign sample_valid = r_valid;
  assign busy         = r_busy;

endmodule

// File: tb/tb_sin_bank.sv
// tb_sin_bank: scoreboard bench for sin_bank.
// Stimulus pushes expected mixes; a monitor pops on each sample_valid.
`timescale 1ns/1ps
module tb_sin_bank;

  localparam int VOICES  = 8;
  localparam int PHASE_W = 32;
  localparam int OUT_W   = 16;
  localparam int GAIN_W  = 8;
  localparam int ITER    = 16;
  localparam int LAT     = 145;
  localparam int TOL     = 4;
  localparam int QUARTER = 32'h4000_0000;
  localparam int PEAK    = 32639;
  localparam int TROUGH  = -32640;

  logic               clk;
  logic               rst;
  logic               cfg_we;
  logic [2:0]         cfg_addr;
  logic               cfg_sel;
  logic [PHASE_W-1:0] cfg_data;
  logic               sample_req;
  logic [OUT_W-1:0]   sample_out;
  logic               sample_valid;
  logic               busy;

  sin_bank #(
    .VOICES(VOICES), .PHASE_W(PHASE_W), .OUT_W(OUT_W),
    .GAIN_W(GAIN_W), .ITER(ITER)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .sample_req(sample_req), .sample_out(sample_out),
    .sample_valid(sample_valid), .busy(busy)
  );

  typedef struct {
    int    exp;
    string name;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_valid  = 0;
  int   cyc      = 0;
  int   t0       = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int mixv(input int acc);
`ifdef SIN_BANK_SAT_EN
    if (acc > 32767) return 32767;
    if (acc < -32767) return -32767;
    return acc;
`else
    return acc >>> 3;
`endif
  endfunction

  task automatic check(input string name, input int act,
                       input int exp, input int tol);
    n_checks++;
    if (act - exp > tol || exp - act > tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)",
               name, act, exp, tol);
    end
  endtask

  always begin
    @(posedge clk);
    #1;
    if (sample_valid) begin
      n_valid++;
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid: got sample %0d, expected none",
                 $signed(sample_out));
      end else begin
        e = q.pop_front();
        check(e.name, int'($signed(sample_out)), e.exp, TOL);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    q.delete();
  endtask

  task automatic cfg_write(input int a, input bit sel, input int d);
    cfg_we   = 1'b1;
    cfg_addr = 3'(a);
    cfg_sel  = sel;
    cfg_data = PHASE_W'(d);
    tick(1);
    cfg_we   = 1'b0;
  endtask

  task automatic start_frame(input int exp, input string name);
    exp_t x;
    x.exp  = exp;
    x.name = name;
    q.push_back(x);
    sample_req = 1'b1;
    tick(1);
    sample_req = 1'b0;
    t0 = cyc;
    check("busy_after_req", int'(busy), 1, 0);
  endtask

  task automatic wait_frame(input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      tick(1);
      if (sample_valid) got = 1'b1;
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got no sample_valid, expected one", name);
    end else begin
      check({name, "_latency"}, cyc - t0, LAT, 0);
      check({name, "_busy_clear"}, int'(busy), 0, 0);
    end
  endtask

  task automatic frame(input int exp, input string name);
    start_frame(exp, name);
    wait_frame(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv0;
    rst        = 1'b1;
    cfg_we     = 1'b0;
    cfg_addr   = '0;
    cfg_sel    = 1'b0;
    cfg_data   = '0;
    sample_req = 1'b0;
    tick(1);
    do_reset();

    check("reset_out", int'($signed(sample_out)), 0, 0);
    check("reset_valid", int'(sample_valid), 0, 0);
    check("reset_busy", int'(busy), 0, 0);
    frame(0, "first_frame");

    cfg_write(0, 1'b0, QUARTER);
    cfg_write(0, 1'b1, 255);
    frame(mixv(0), "v0_f1");
    frame(mixv(PEAK), "v0_f2");
    frame(mixv(0), "v0_f3");
    frame(mixv(TROUGH), "v0_f4");

    do_reset();
    for (int v = 0; v < VOICES; v++) begin
      cfg_write(v, 1'b0, QUARTER);
      cfg_write(v, 1'b1, 255);
    end
    frame(mixv(0), "all_f1");
    frame(mixv(8 * PEAK), "all_f2");

    do_reset();
    nv0 = n_valid;
    start_frame(0, "ign");
    while (cyc < t0 + 9) tick(1);
    sample_req = 1'b1;
    tick(1);
    sample_req = 1'b0;
    while (cyc < t0 + 99) tick(1);
    sample_req = 1'b1;
    tick(1);
    sample_req = 1'b0;
    wait_frame("ign");
    tick(200);
    check("ign_valid_count", n_valid - nv0, 1, 0);

    do_reset();
    cfg_write(0, 1'b0, QUARTER);
    cfg_write(0, 1'b1, 255);
    frame(mixv(0), "abort_pre");
    start_frame(mixv(PEAK), "abort");
    while (cyc < t0 + 19) tick(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("abort_busy", int'(busy), 0, 0);
    q.delete();
    nv0 = n_valid;
    tick(200);
    check("abort_no_valid", n_valid - nv0, 0, 0);
    cfg_write(0, 1'b1, 255);
    frame(mixv(0), "abort_post");

    do_reset();
    start_frame(mixv(0), "late_f1");
    tick(2);
    cfg_write(7, 1'b0, QUARTER);
    cfg_write(7, 1'b1, 255);
    wait_frame("late_f1");
    frame(mixv(PEAK), "late_f2");

    tick(5);
    check("queue_drained", q.size(), 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
